// File: rtl/multiplicador_algoritmico.sv
// Signed shift-and-add recomposer: Num = Coc*Den + Res, one multiplier bit per two cycles.
// Optional operand consistency flag enabled by defining CONSISTENCY_CHECK_EN.
module multiplicador_algoritmico #(
    parameter int unsigned tamanyo = 32
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic [tamanyo-1:0] Coc,
    input  logic [tamanyo-1:0] Den,
    input  logic [tamanyo-1:0] Res,
    output logic [tamanyo-1:0] Num,
    output logic               Ovf,
    output logic               Err,
    output logic               Done
);

    localparam int unsigned N  = tamanyo;
    localparam int unsigned CW = $clog2(tamanyo);
    localparam logic [CW-1:0] ContInit = CW'(tamanyo - 1);
    localparam logic [CW-1:0] ContOne  = CW'(1);

    typedef enum logic [1:0] {D0, D1, D2, D3} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  accu_q, accu_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  r_q, r_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          sign_q, sign_d;
    logic          c_q, c_d;
    logic [N-1:0]  num_q, num_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [N-1:0]   coc_abs, den_abs;
    logic [2*N-1:0] prod_mag, prod_signed, sum_full;
    logic           sum_ovf;

    always_comb begin
        coc_abs = Coc[N-1] ? ({N{1'b0}} - Coc) : Coc;
        den_abs = Den[N-1] ? ({N{1'b0}} - Den) : Den;
    end

    // Magnitude product cannot exceed 2^(2N-2), so the signed sum never wraps in 2N bits.
    always_comb begin
        prod_mag    = {accu_q, q_q};
        prod_signed = sign_q ? ({(2*N){1'b0}} - prod_mag) : prod_mag;
        sum_full    = prod_signed + {{N{r_q[N-1]}}, r_q};
        sum_ovf     = ~((&sum_full[2*N-1:N-1]) | ~(|sum_full[2*N-1:N-1]));
    end

    // State register and datapath flops
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= D0;
            accu_q  <= '0;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cont_q  <= '0;
            sign_q  <= 1'b0;
            c_q     <= 1'b0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            accu_q  <= accu_d;
            q_q     <= q_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cont_q  <= cont_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = D0;
        unique case (state_q)
            D0:      state_d = Start ? D1 : D0;
            D1:      state_d = D2;
            D2:      state_d = (cont_q == '0) ? D3 : D1;
            D3:      state_d = D0;
            default: state_d = D0;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        accu_d = accu_q;
        q_d    = q_q;
        m_d    = m_q;
        r_d    = r_q;
        cont_d = cont_q;
        sign_d = sign_q;
        c_d    = c_q;
        num_d  = num_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        unique case (state_q)
            D0: begin
                if (Start) begin
                    m_d    = den_abs;
                    q_d    = coc_abs;
                    r_d    = Res;
                    accu_d = '0;
                    c_d    = 1'b0;
                    cont_d = ContInit;
                    sign_d = Coc[N-1] ^ Den[N-1];
                end
            end
            D1: begin
                if (q_q[0]) begin
                    {c_d, accu_d} = {1'b0, accu_q} + {1'b0, m_q};
                end
            end
            D2: begin
                {c_d, accu_d, q_d} = {1'b0, c_q, accu_q, q_q[N-1:1]};
                cont_d             = cont_q - ContOne;
            end
            D3: begin
                num_d  = sum_full[N-1:0];
                ovf_d  = sum_ovf;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign Num  = num_q;
    assign Ovf  = ovf_q;
    assign Done = done_q;

`ifdef CONSISTENCY_CHECK_EN
    logic         err_q, err_d;
    logic [N-1:0] r_abs;
    logic         err_cond;

    // M holds |Den|, so Den==0 is M==0; the remainder must be smaller and share the result sign.
    always_comb begin
        r_abs    = r_q[N-1] ? ({N{1'b0}} - r_q) : r_q;
        err_cond = (m_q == '0) || (r_abs >= m_q) ||
                   ((r_q != '0) && (r_q[N-1] != sum_full[2*N-1]));
        err_d    = (state_q == D3) ? err_cond : err_q;
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTa && state_q == D3 && err_cond) begin
            $error("multiplicador_algoritmico: inconsistent operands |Den|=%0d Res=%0h sign=%0b",
                   m_q, r_q, sign_q);
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule
